// File: rtl/alu_share_arbiter_if.sv
// Request, shared-ALU and response bundle for alu_share_arbiter.
// The arbiter binds to slave; requesters, ALU and consumers sit on master.
interface alu_share_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic [2:0]  req0_funct3;
    logic [6:0]  req0_funct7;

    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic [2:0]  req1_funct3;
    logic [6:0]  req1_funct7;

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_funct3;
    logic [6:0]  alu_funct7;
    logic [31:0] alu_result;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp_result;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_funct3, req0_funct7,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_funct3, req1_funct7,
        output req1_ready,
        output alu_a, alu_b, alu_funct3, alu_funct7,
        input  alu_result,
        output rsp0_valid, rsp1_valid, rsp_result,
        input  rsp0_ready, rsp1_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_funct3, req0_funct7,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_funct3, req1_funct7,
        input  req1_ready,
        input  alu_a, alu_b, alu_funct3, alu_funct7,
        output alu_result,
        input  rsp0_valid, rsp1_valid, rsp_result,
        output rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter sharing one combinational ALU, with a single
// registered result stage returned to the issuing port.
module alu_share_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input logic           clk,
    input logic           rst,
    alu_share_arbiter_if.slave bus
);

    logic        out_valid;
    logic        out_owner;
    logic [31:0] out_result;
    logic        last_grant;

    logic        gnt_vld;
    logic        gnt;
    logic        owner_rdy;
    logic        can_accept;
    logic        accept;

    always_comb begin
        gnt_vld = bus.req0_valid | bus.req1_valid;
        gnt     = 1'b0;
        case ({bus.req1_valid, bus.req0_valid})
            2'b11:   gnt = RR_EN ? ~last_grant : 1'b0;
            2'b10:   gnt = 1'b1;
            default: gnt = 1'b0;
        endcase
    end

    assign owner_rdy  = out_owner ? bus.rsp1_ready : bus.rsp0_ready;
    assign can_accept = !out_valid || owner_rdy;

    assign bus.req0_ready = can_accept && gnt_vld && !gnt && !rst;
    assign bus.req1_ready = can_accept && gnt_vld && gnt && !rst;

    assign accept = (bus.req0_valid && bus.req0_ready) ||
                    (bus.req1_valid && bus.req1_ready);

    // Idle ALU inputs are forced to zero so the shared unit sees no toggling.
    always_comb begin
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_funct3 = '0;
        bus.alu_funct7 = '0;
        if (gnt_vld) begin
            if (gnt) begin
                bus.alu_a      = bus.req1_a;
                bus.alu_b      = bus.req1_b;
                bus.alu_funct3 = bus.req1_funct3;
                bus.alu_funct7 = bus.req1_funct7;
            end else begin
                bus.alu_a      = bus.req0_a;
                bus.alu_b      = bus.req0_b;
                bus.alu_funct3 = bus.req0_funct3;
                bus.alu_funct7 = bus.req0_funct7;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_owner  <= 1'b0;
            out_result <= '0;
            last_grant <= 1'b1;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_owner  <= gnt;
            out_result <= bus.alu_result;
            last_grant <= gnt;
        end else if (out_valid && owner_rdy) begin
            out_valid  <= 1'b0;
        end
    end

    assign bus.rsp0_valid = out_valid && !out_owner;
    assign bus.rsp1_valid = out_valid && out_owner;
    assign bus.rsp_result = out_result;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_share_arbiter_if bus ();
    alu_share_arbiter_if fbus ();

    alu_share_arbiter #(.RR_EN(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    alu_share_arbiter #(.RR_EN(1'b0)) dutf (
        .clk(clk),
        .rst(rst),
        .bus(fbus)
    );

    function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b,
                                          logic [2:0] f3, logic [6:0] f7);
        case (f3)
            3'd0: return (f7 == 7'h20) ? a - b : a + b;
            3'd1: return a << b[4:0];
            3'd2: return {31'd0, $signed(a) < $signed(b)};
            3'd3: return {31'd0, a < b};
            3'd4: return a ^ b;
            3'd5: return (f7 == 7'h20) ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    logic        pv[2];
    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic [2:0]  pf3[2];
    logic [6:0]  pf7[2];
    logic        rdy[2];

    assign bus.req0_valid  = pv[0];
    assign bus.req0_a      = pa[0];
    assign bus.req0_b      = pb[0];
    assign bus.req0_funct3 = pf3[0];
    assign bus.req0_funct7 = pf7[0];
    assign bus.req1_valid  = pv[1];
    assign bus.req1_a      = pa[1];
    assign bus.req1_b      = pb[1];
    assign bus.req1_funct3 = pf3[1];
    assign bus.req1_funct7 = pf7[1];
    assign bus.rsp0_ready  = rdy[0];
    assign bus.rsp1_ready  = rdy[1];
    assign bus.alu_result  = alu_f(bus.alu_a, bus.alu_b, bus.alu_funct3, bus.alu_funct7);

    assign fbus.req0_valid  = pv[0];
    assign fbus.req0_a      = pa[0];
    assign fbus.req0_b      = pb[0];
    assign fbus.req0_funct3 = pf3[0];
    assign fbus.req0_funct7 = pf7[0];
    assign fbus.req1_valid  = pv[1];
    assign fbus.req1_a      = pa[1];
    assign fbus.req1_b      = pb[1];
    assign fbus.req1_funct3 = pf3[1];
    assign fbus.req1_funct7 = pf7[1];
    assign fbus.rsp0_ready  = rdy[0];
    assign fbus.rsp1_ready  = rdy[1];
    assign fbus.alu_result  = alu_f(fbus.alu_a, fbus.alu_b, fbus.alu_funct3, fbus.alu_funct7);

    typedef struct {
        int          port;
        logic [31:0] res;
    } exp_t;

    exp_t q[$];
    int   last_m = 1;
    int   passed = 0;
    int   total  = 0;
    bit   mon_en = 1'b0;
    bit   fp_chk = 1'b0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    endtask

    // Model: at most one result outstanding (queue head); round-robin
    // winner is the port that did not win last time.
    task automatic step(output int acc);
        int win;
        bit can;
        win = -1;
        @(negedge clk);
        #1;
        if (rst) begin
            chk("ready_in_rst", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        end else begin
            can = (q.size() == 0) || rdy[q[0].port];
            if (can) begin
                if (pv[0] && pv[1]) win = (last_m == 0) ? 1 : 0;
                else if (pv[0]) win = 0;
                else if (pv[1]) win = 1;
            end
            chk("req0_ready", 32'(bus.req0_ready), 32'(win == 0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(win == 1));
            if (fp_chk) begin
                chk("fp_req0_ready", 32'(fbus.req0_ready), 32'd1);
                chk("fp_req1_ready", 32'(fbus.req1_ready), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            q.delete();
            last_m = 1;
        end else if (win >= 0) begin
            q.push_back('{win, alu_f(pa[win], pb[win], pf3[win], pf7[win])});
            last_m = win;
        end
        acc = win;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                chk("rsp0_valid", 32'(bus.rsp0_valid),
                    32'(q.size() > 0 && q[0].port == 0));
                chk("rsp1_valid", 32'(bus.rsp1_valid),
                    32'(q.size() > 0 && q[0].port == 1));
                if (q.size() > 0) begin
                    chk("rsp_result", bus.rsp_result, q[0].res);
                    if (!rst && rdy[q[0].port]) void'(q.pop_front());
                end
            end
        end
    end

    task automatic set_req(int p, logic [31:0] a, logic [31:0] b,
                           logic [2:0] f3, logic [6:0] f7);
        pv[p]  = 1'b1;
        pa[p]  = a;
        pb[p]  = b;
        pf3[p] = f3;
        pf7[p] = f7;
    endtask

    task automatic do_reset();
        int acc;
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        for (int p = 0; p < 2; p++) begin
            pv[p] = 1'b0; pa[p] = '0; pb[p] = '0; pf3[p] = '0; pf7[p] = '0;
            rdy[p] = 1'b1;
        end

        rst = 1'b1;
        step(acc);
        step(acc);
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("reset_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("reset_rsp_result", bus.rsp_result, 32'd0);

        set_req(0, 32'd5, 32'd3, 3'd0, 7'h00);
        step(acc);
        pv[0] = 1'b0;
        chk("single_grant", 32'(acc), 32'd0);
        chk("single_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        chk("single_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("single_result", bus.rsp_result, 32'd8);

        do_reset();
        set_req(0, 32'd1, 32'd1, 3'd0, 7'h00);
        set_req(1, 32'hF0, 32'h0F, 3'd4, 7'h00);
        for (int i = 0; i < 6; i++) begin
            step(acc);
            chk("rr_grant", 32'(acc), 32'(i % 2));
            chk("rr_result", bus.rsp_result, (i % 2 == 0) ? 32'd2 : 32'hFF);
        end
        pv[0] = 1'b0;
        pv[1] = 1'b0;

        set_req(1, 32'hFFFF_FFF0, 32'd4, 3'd5, 7'h20);
        step(acc);
        pv[1] = 1'b0;
        chk("bp_grant", 32'(acc), 32'd1);
        rdy[1] = 1'b0;
        set_req(0, 32'd7, 32'd8, 3'd0, 7'h00);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            chk("bp_stall_grant", 32'(acc), 32'hFFFF_FFFF);
            chk("bp_hold_result", bus.rsp_result, 32'hFFFF_FFFF);
        end
        rdy[1] = 1'b1;
        step(acc);
        pv[0] = 1'b0;
        chk("bp_release_grant", 32'(acc), 32'd0);
        chk("bp_release_result", bus.rsp_result, 32'd15);

        do_reset();
        set_req(0, 32'd2, 32'd2, 3'd6, 7'h00);
        set_req(1, 32'd9, 32'd4, 3'd1, 7'h00);
        fp_chk = 1'b1;
        for (int i = 0; i < 5; i++) step(acc);
        fp_chk = 1'b0;
        pv[0] = 1'b0;
        pv[1] = 1'b0;

        set_req(1, 32'd1, 32'd2, 3'd0, 7'h00);
        step(acc);
        pv[1] = 1'b0;
        chk("rop_grant", 32'(acc), 32'd1);
        rdy[1] = 1'b0;
        step(acc);
        set_req(0, 32'd4, 32'd4, 3'd0, 7'h00);
        set_req(1, 32'd6, 32'd3, 3'd3, 7'h00);
        do_reset();
        chk("rop_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rop_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("rop_rsp_result", bus.rsp_result, 32'd0);
        rdy[1] = 1'b1;
        step(acc);
        chk("rop_first_grant", 32'(acc), 32'd0);
        step(acc);
        chk("rop_second_grant", 32'(acc), 32'd1);
        pv[0] = 1'b0;
        pv[1] = 1'b0;

        set_req(0, 32'd3, 32'd5, 3'd0, 7'h20);
        step(acc);
        pv[0] = 1'b0;
        chk("sub_result", bus.rsp_result, 32'hFFFF_FFFE);
        set_req(0, 32'hFFFF_FFFF, 32'd1, 3'd2, 7'h00);
        step(acc);
        pv[0] = 1'b0;
        chk("slt_result", bus.rsp_result, 32'd1);

        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p] && $urandom_range(0, 1) == 1) begin
                    logic [2:0] f3;
                    f3 = 3'($urandom_range(0, 7));
                    set_req(p, $urandom, $urandom, f3,
                            ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1)
                            ? 7'h20 : 7'h00);
                end
                rdy[p] = ($urandom_range(0, 3) != 0);
            end
            rst = ($urandom_range(0, 49) == 0);
            step(acc);
            if (acc >= 0) pv[acc] = 1'b0;
        end
        rst = 1'b0;

        pv[0] = 1'b0;
        pv[1] = 1'b0;
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        for (int i = 0; i < 3; i++) step(acc);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one combinational ALU instance between two requesters, for example the execute stage (port 0) and a branch/address-generation unit (port 1). Requests use a valid/ready handshake. Requests are granted round-robin or by fixed priority, and the ALU result is captured in a single registered output stage. Each result is returned to the port that issued it, one cycle after acceptance, with back-pressure.

## Interface
Parameters:
- RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where port 0 always wins.

Ports. Clock is `clk`; reset is `rst`, which is synchronous and active-high.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  request from port N (N = 0, 1).
- reqN_ready  out  1  port N request accepted this cycle when reqN_valid is also 1.
- reqN_a, reqN_b  in  32  operands for port N.
- reqN_funct3  in  3  ALU operation select for port N.
- reqN_funct7  in  7  ALU operation modifier for port N (0x20 selects SUB/SRA).
- alu_a, alu_b  out  32  operands driven to the shared ALU.
- alu_funct3  out  3  operation select driven to the ALU.
- alu_funct7  out  7  operation modifier driven to the ALU.
- alu_result  in  32  combinational result returned by the ALU.
- rspN_valid  out  1  result pending for port N.
- rspN_ready  in  1  port N consumes the result.
- rsp_result  out  32  registered result, shared by both response ports.

## Operation
State:
- out_valid (1 bit), out_owner (1 bit), out_result (32 bits), last_grant (1 bit).
- No other state.

Response outputs:
- rspN_valid = out_valid && (out_owner == N).
- rsp_result = out_result.

Stage free condition:
- can_accept = !out_valid || rsp_ready of out_owner.

Grant selection (combinational):
- Only one port valid: grant that port.
- Both valid, RR_EN=1: grant the port that is not last_grant.
- Both valid, RR_EN=0: grant port 0.
- Neither valid: no grant.

Ready and ALU drive:
- reqN_ready = can_accept && (grant == N) && !rst.
- At most one reqN_ready is high in any cycle.
- With a grant, the granted port's a/b/funct3/funct7 are muxed onto alu_*.
- With no grant, alu_a = alu_b = 0, alu_funct3 = 0, alu_funct7 = 0.

On acceptance (reqN_valid && reqN_ready):
- out_result <= alu_result
- out_owner <= N
- out_valid <= 1
- last_grant <= N

Drain:
- If the pending response is consumed and no request is accepted that cycle, out_valid <= 0.
- Accepting a new request while draining the old result in the same cycle is legal; the new result replaces the old one with no bubble.

Stall:
- While out_valid && !rsp_ready of out_owner, out_result and out_owner are held and no request is accepted.
- last_grant does not change during a stall.

Requester contract:
- A requester holds valid and operands stable until accepted.
- Grant may move between ports before acceptance, for example when port 1 becomes valid while port 0 is stalled. This is legal because nothing was accepted.

Arithmetic:
- The arbiter performs no arithmetic and does not modify operand widths; operands and result pass through unchanged.

## Timing
Reset (rst=1 at a clock edge):
- out_valid=0, out_owner=0, out_result=0, last_grant=1, so port 0 wins the first contention.
- rsp0_valid=0, rsp1_valid=0, rsp_result=0.
- req0_ready=0 and req1_ready=0 while rst is high.

Latency and throughput:
- Latency: a request accepted at edge N has its response valid at edge N+1, i.e. visible in the cycle after acceptance.
- Throughput: 1 operation per cycle while the consuming rsp_ready stays high.
- Two ports both continuously valid with RR_EN=1: grants alternate 0,1,0,1.

Reset during operation:
- A pending, unconsumed response is discarded.
- A request presented in the same cycle as rst is not accepted.

Response readiness:
- rspN_ready asserted while rspN_valid=0 has no effect.

## Test plan
- Single request: port 0 sends A=5, B=3, funct3=0, funct7=0; req0_ready=1 that cycle. Next cycle rsp0_valid=1, rsp1_valid=0, rsp_result=8.
- Contention after reset: both ports valid from the first post-reset cycle (port 0 ADD 1+1, port 1 XOR 0xF0^0x0F), rsp ready always high. Grant order is 0,1,0,1; results alternate 2 and 0xFF; no idle cycles.
- Back-pressure: port 1 issues SRA with A=0xFFFFFFF0, B=4, funct3=5, funct7=0x20; hold rsp1_ready=0 for 3 cycles.
  - rsp_result=0xFFFFFFFF stays stable throughout.
  - req0_ready and req1_ready stay 0.
  - When rsp1_ready rises, a waiting port 0 request is accepted in that same cycle.
- Fixed priority: with RR_EN=0, both ports continuously valid. Port 0 is granted every cycle and req1_ready is never 1.
- Reset during operation: assert rst while a response is pending and stalled. The next cycle rsp0_valid=0, rsp1_valid=0, rsp_result=0, and the first contention after reset goes to port 0.
- SUB and SLT pass-through: SUB 3-5 on port 0 gives 0xFFFFFFFE. SLT with A=0xFFFFFFFF, B=1 (funct3=2) gives 1.
